rwt_axis_tag_insert: RTL and testbench

//  Inserts in-band tags into a 64-bit AXI-Stream. A word with a tag request is

---
 rtl/rwt_axis_tag_insert.sv | 161 ++++++++++++++++
 tb/tb_rwt_axis_tag_insert.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rwt_axis_tag_insert.sv
// ---------------------------------------------------------------------------
// rwt_axis_tag_insert
//
// Inserts in-band tags into an AXI-Stream. A word that carries a tag request
// is preceded by a two-word escape sequence: the escape word, then a control
// word whose bit 7 is set and whose low bits carry the tag type. A payload
// word that happens to equal the escape word is sent as escape word plus an
// all-zero control word. That control word carries the original keep/last,
// so the downstream sink can rebuild the literal without a third word.
//
// Ports
//   clk              single clock, rising edge
//   aresetn          asynchronous active-low reset (release synchronised)
//   use_tags         1 = tag insertion / escaping enabled, 0 = passthrough
//   tag_escape       escape word value
//   s_axi_t*         upstream AXI-Stream slave (data/keep/last/valid/ready)
//   s_axi_tag_valid  current input word carries a tag (qualified by tvalid)
//   s_axi_tag_type   tag type for the current input word
//   m_axi_t*         downstream AXI-Stream master (data/keep/last/valid/ready)
// ---------------------------------------------------------------------------
module rwt_axis_tag_insert #(
    parameter int unsigned DWIDTH  = 64,
    parameter int unsigned TTWIDTH = 7
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  use_tags,
    input  logic [DWIDTH-1:0]     tag_escape,
    input  logic [DWIDTH-1:0]     s_axi_tdata,
    input  logic [DWIDTH/8-1:0]   s_axi_tkeep,
    input  logic                  s_axi_tlast,
    input  logic                  s_axi_tvalid,
    output logic                  s_axi_tready,
    input  logic                  s_axi_tag_valid,
    input  logic [TTWIDTH-1:0]    s_axi_tag_type,
    output logic [DWIDTH-1:0]     m_axi_tdata,
    output logic [DWIDTH/8-1:0]   m_axi_tkeep,
    output logic                  m_axi_tlast,
    output logic                  m_axi_tvalid,
    input  logic                  m_axi_tready
);

    localparam int unsigned KWIDTH = DWIDTH / 8;

    localparam logic [1:0] ST_PASS = 2'd0;
    localparam logic [1:0] ST_CTRL = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Reset synchroniser: assertion is immediate, release takes two clocks.
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    logic [1:0]         state_q, state_d;
    logic               is_tag_q, is_tag_d;
    logic [TTWIDTH-1:0] tag_type_q, tag_type_d;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_PASS;
            is_tag_q   <= 1'b0;
            tag_type_q <= '0;
        end else begin
            state_q    <= state_d;
            is_tag_q   <= is_tag_d;
            tag_type_q <= tag_type_d;
        end
    end

    logic              esc_needed;
    logic [DWIDTH-1:0] ctrl_word;
    logic [DWIDTH-1:0] out_data;
    logic [KWIDTH-1:0] out_keep;
    logic              out_last;
    logic              out_valid;
    logic              in_ready;

    assign esc_needed = use_tags && s_axi_tvalid &&
                        (s_axi_tag_valid || (s_axi_tdata == tag_escape));

    always_comb begin
        state_d    = state_q;
        is_tag_d   = is_tag_q;
        tag_type_d = tag_type_q;

        ctrl_word = '0;
        if (is_tag_q) begin
            ctrl_word[7]           = 1'b1;
            ctrl_word[TTWIDTH-1:0] = tag_type_q;
        end

        // Passthrough is the default; states override only what differs.
        out_data  = s_axi_tdata;
        out_keep  = s_axi_tkeep;
        out_last  = s_axi_tlast;
        out_valid = s_axi_tvalid;
        in_ready  = m_axi_tready;

        case (state_q)
            ST_PASS: begin
                if (esc_needed) begin
                    out_data  = tag_escape;
                    out_keep  = '1;
                    out_last  = 1'b0;
                    out_valid = 1'b1;
                    in_ready  = 1'b0;
                    if (run && m_axi_tready) begin
                        state_d    = ST_CTRL;
                        // A tag request wins over the literal case.
                        is_tag_d   = s_axi_tag_valid;
                        tag_type_d = s_axi_tag_type;
                    end
                end
            end
            ST_CTRL: begin
                out_data  = ctrl_word;
                out_valid = 1'b1;
                if (is_tag_q) begin
                    out_keep = '1;
                    out_last = 1'b0;
                    in_ready = 1'b0;
                    if (run && m_axi_tready) begin
                        state_d = ST_DATA;
                    end
                end else begin
                    // Literal: the control word stands in for the input word,
                    // so it carries its keep/last and consumes it.
                    if (run && m_axi_tready) begin
                        state_d = ST_PASS;
                    end
                end
            end
            ST_DATA: begin
                if (run && m_axi_tready && s_axi_tvalid) begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d   = ST_PASS;
                out_valid = 1'b0;
                in_ready  = 1'b0;
            end
        endcase
    end

    assign m_axi_tvalid = run && out_valid;
    assign s_axi_tready = run && in_ready;
    assign m_axi_tdata  = run ? out_data : '0;
    assign m_axi_tkeep  = run ? out_keep : '0;
    assign m_axi_tlast  = run && out_last;

endmodule

// File: tb/tb_rwt_axis_tag_insert.sv
module tb_rwt_axis_tag_insert;

    localparam logic [63:0] ESC = 64'hAAAA_AAAA_AAAA_AAAA;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        use_tags;
    logic [63:0] tag_escape;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tag_valid;
    logic [6:0]  s_tag_type;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;

    always #5 clk = ~clk;

    rwt_axis_tag_insert #(.DWIDTH(64), .TTWIDTH(7)) dut (
        .clk(clk), .aresetn(aresetn), .use_tags(use_tags), .tag_escape(tag_escape),
        .s_axi_tdata(s_tdata), .s_axi_tkeep(s_tkeep), .s_axi_tlast(s_tlast),
        .s_axi_tvalid(s_tvalid), .s_axi_tready(s_tready),
        .s_axi_tag_valid(s_tag_valid), .s_axi_tag_type(s_tag_type),
        .m_axi_tdata(m_tdata), .m_axi_tkeep(m_tkeep), .m_axi_tlast(m_tlast),
        .m_axi_tvalid(m_tvalid), .m_axi_tready(m_tready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t expq[$];
    beat_t gotq[$];

    // Reference: what the escape rules say the output stream must be.
    function automatic void model_push(input logic ut, input logic [63:0] d, input logic [7:0] k,
                                       input logic l, input logic tv, input logic [6:0] tt);
        if (ut && tv) begin
            expq.push_back('{ESC, 8'hFF, 1'b0});
            expq.push_back('{64'h80 + 64'(tt), 8'hFF, 1'b0});
            expq.push_back('{d, k, l});
        end else if (ut && d == ESC) begin
            expq.push_back('{ESC, 8'hFF, 1'b0});
            expq.push_back('{64'h0, k, l});
        end else begin
            expq.push_back('{d, k, l});
        end
    endfunction

    typedef struct {
        logic        ut;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        tv;
        logic [6:0]  tt;
        int          n;
        logic [2:0][63:0] od;
        logic [2:0][7:0]  ok;
        logic [2:0]       ol;
    } vec_t;

    function automatic vec_t mk(input logic ut, input logic [63:0] d, input logic [7:0] k,
                                input logic l, input logic tv, input logic [6:0] tt, input int n,
                                input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                                input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2,
                                input logic [2:0] ol);
        vec_t v;
        v.ut = ut; v.d = d; v.k = k; v.l = l; v.tv = tv; v.tt = tt; v.n = n;
        v.od = {d2, d1, d0};
        v.ok = {k2, k1, k0};
        v.ol = ol;
        return v;
    endfunction

    vec_t vt[8];

    logic [63:0] in_d[256];
    logic [7:0]  in_k[256];
    logic        in_l[256];
    logic        in_tv[256];
    logic [6:0]  in_tt[256];

    task automatic run_random(input string tag, input logic ut, input int n);
        int     idx;
        bit     presenting;
        bit     prev_stall;
        beat_t  prev;
        int     r;
        expq.delete();
        gotq.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 3);
            in_d[i]  = (r == 0) ? ESC : (r == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
            in_k[i]  = 8'($urandom);
            in_l[i]  = 1'($urandom_range(0, 1));
            in_tv[i] = ($urandom_range(0, 3) == 0);
            in_tt[i] = 7'($urandom);
            model_push(ut, in_d[i], in_k[i], in_l[i], in_tv[i], in_tt[i]);
        end
        use_tags   = ut;
        idx        = 0;
        presenting = 0;
        prev_stall = 0;
        prev       = '{64'h0, 8'h0, 1'b0};
        for (int c = 0; c < 4000 && idx < n; c++) begin
            if (!presenting && $urandom_range(0, 3) != 0) begin
                s_tdata = in_d[idx]; s_tkeep = in_k[idx]; s_tlast = in_l[idx];
                s_tag_valid = in_tv[idx]; s_tag_type = in_tt[idx]; s_tvalid = 1'b1;
                presenting = 1;
            end else if (!presenting) begin
                s_tvalid = 1'b0;
                s_tdata = {$urandom, $urandom};
                s_tag_valid = 1'($urandom_range(0, 1));
            end
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                chk({tag, ".hold_valid"}, 64'(m_tvalid), 64'h1);
                chk({tag, ".hold_data"}, m_tdata, prev.d);
                chk({tag, ".hold_kl"}, {55'h0, m_tkeep, m_tlast}, {55'h0, prev.k, prev.l});
            end
            if (m_tvalid && m_tready) gotq.push_back('{m_tdata, m_tkeep, m_tlast});
            if (s_tvalid && s_tready) begin
                idx++;
                presenting = 0;
            end
            prev_stall = m_tvalid && !m_tready;
            prev       = '{m_tdata, m_tkeep, m_tlast};
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        chk({tag, ".consumed"}, 64'(idx), 64'(n));
        chk({tag, ".count"}, 64'(gotq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            chk($sformatf("%s.w%0d.data", tag, i), gotq[i].d, expq[i].d);
            chk($sformatf("%s.w%0d.kl", tag, i), {55'h0, gotq[i].k, gotq[i].l},
                {55'h0, expq[i].k, expq[i].l});
        end
    endtask

    initial begin
        beat_t       hold;
        bit          stall;
        bit          done;

        vt[0] = mk(1, 64'h1, 8'hFF, 0, 0, 7'h00, 1, 64'h1, 0, 0, 8'hFF, 0, 0, 3'b000);
        vt[1] = mk(1, 64'h2, 8'hFF, 0, 0, 7'h00, 1, 64'h2, 0, 0, 8'hFF, 0, 0, 3'b000);
        vt[2] = mk(1, 64'h3, 8'hFF, 1, 0, 7'h00, 1, 64'h3, 0, 0, 8'hFF, 0, 0, 3'b001);
        vt[3] = mk(1, 64'h55, 8'hFF, 0, 1, 7'h05, 3, ESC, 64'h85, 64'h55, 8'hFF, 8'hFF, 8'hFF, 3'b000);
        vt[4] = mk(1, ESC, 8'h0F, 1, 0, 7'h00, 2, ESC, 64'h0, 0, 8'hFF, 8'h0F, 0, 3'b010);
        vt[5] = mk(0, 64'h55, 8'hFF, 0, 1, 7'h05, 1, 64'h55, 0, 0, 8'hFF, 0, 0, 3'b000);
        vt[6] = mk(0, ESC, 8'h03, 1, 0, 7'h00, 1, ESC, 0, 0, 8'h03, 0, 0, 3'b001);
        vt[7] = mk(1, ESC, 8'hFF, 0, 1, 7'h7F, 3, ESC, 64'hFF, ESC, 8'hFF, 8'hFF, 8'hFF, 3'b000);

        aresetn = 1'b0; use_tags = 1'b1; tag_escape = ESC;
        s_tdata = 64'h1234; s_tkeep = 8'hFF; s_tlast = 1'b1; s_tvalid = 1'b1;
        s_tag_valid = 1'b0; s_tag_type = '0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.m_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst.s_tready", 64'(s_tready), 64'h0);
        chk("rst.m_tdata", m_tdata, 64'h0);
        chk("rst.m_tkl", {55'h0, m_tkeep, m_tlast}, 64'h0);
        s_tvalid = 1'b0;
        aresetn  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Table-driven single-word cases with the sink always ready.
        for (int i = 0; i < 8; i++) begin
            use_tags = vt[i].ut; s_tdata = vt[i].d; s_tkeep = vt[i].k; s_tlast = vt[i].l;
            s_tag_valid = vt[i].tv; s_tag_type = vt[i].tt; s_tvalid = 1'b1;
            for (int j = 0; j < vt[i].n; j++) begin
                #1;
                chk($sformatf("v%0d.w%0d.valid", i, j), 64'(m_tvalid), 64'h1);
                chk($sformatf("v%0d.w%0d.data", i, j), m_tdata, vt[i].od[j]);
                chk($sformatf("v%0d.w%0d.keep", i, j), 64'(m_tkeep), 64'(vt[i].ok[j]));
                chk($sformatf("v%0d.w%0d.last", i, j), 64'(m_tlast), 64'(vt[i].ol[j]));
                chk($sformatf("v%0d.w%0d.sready", i, j), 64'(s_tready), 64'(j == vt[i].n - 1));
                @(posedge clk); #1;
            end
            s_tvalid = 1'b0;
        end

        // Tagged word under random backpressure.
        use_tags = 1'b1; s_tdata = 64'h55; s_tkeep = 8'hFF; s_tlast = 1'b0;
        s_tag_valid = 1'b1; s_tag_type = 7'h05; s_tvalid = 1'b1;
        gotq.delete();
        stall = 0; done = 0; hold = '{64'h0, 8'h0, 1'b0};
        for (int c = 0; c < 60 && !done; c++) begin
            m_tready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stall) begin
                chk("bp.hold_valid", 64'(m_tvalid), 64'h1);
                chk("bp.hold_data", m_tdata, hold.d);
                chk("bp.hold_kl", {55'h0, m_tkeep, m_tlast}, {55'h0, hold.k, hold.l});
            end
            if (m_tvalid && m_tready) gotq.push_back('{m_tdata, m_tkeep, m_tlast});
            if (s_tvalid && s_tready) done = 1;
            stall = m_tvalid && !m_tready;
            hold  = '{m_tdata, m_tkeep, m_tlast};
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        chk("bp.accepted", 64'(done), 64'h1);
        chk("bp.count", 64'(gotq.size()), 64'h3);
        if (gotq.size() == 3) begin
            chk("bp.w0", gotq[0].d, ESC);
            chk("bp.w1", gotq[1].d, 64'h85);
            chk("bp.w2", gotq[2].d, 64'h55);
        end

        // Reset while the control word is being presented.
        s_tdata = 64'h66; s_tkeep = 8'hFF; s_tlast = 1'b0;
        s_tag_valid = 1'b1; s_tag_type = 7'h03; s_tvalid = 1'b1; m_tready = 1'b1;
        #1;
        chk("rc.esc", m_tdata, ESC);
        @(posedge clk); #1;
        m_tready = 1'b0;
        #1;
        chk("rc.ctrl", m_tdata, 64'h83);
        aresetn = 1'b0;
        #1;
        chk("rc.valid_low", 64'(m_tvalid), 64'h0);
        chk("rc.ready_low", 64'(s_tready), 64'h0);
        chk("rc.data_zero", m_tdata, 64'h0);
        s_tvalid = 1'b0; s_tag_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_tready = 1'b1;
        #1;
        chk("rc.idle_valid", 64'(m_tvalid), 64'h0);
        s_tdata = 64'h77; s_tvalid = 1'b1;
        #1;
        chk("rc.pass_valid", 64'(m_tvalid), 64'h1);
        chk("rc.pass_data", m_tdata, 64'h77);
        chk("rc.pass_ready", 64'(s_tready), 64'h1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;

        run_random("rnd_on", 1'b1, 200);
        run_random("rnd_off", 1'b0, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
